// File: rtl/mod_counter_pkg.sv
// rtl/mod_counter_pkg.sv - shared FSM encoding for the modulo counter scheduler
package mod_counter_pkg;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_RUN   = 2'd1;
   localparam logic [1:0] S_PAUSE = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE  = S_IDLE,
      ST_RUN   = S_RUN,
      ST_PAUSE = S_PAUSE,
      ST_DONE  = S_DONE
   } state_t;

endpackage

// File: rtl/mod_counter_scheduler_period_counter.sv
// rtl/mod_counter_scheduler_period_counter.sv - 0..terminal counter with wrap flag
module period_counter #(
   parameter int BITS = 8
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            en,
   input  logic            clr,
   input  logic [BITS-1:0] terminal,
   output logic [BITS-1:0] q,
   output logic            wrap
);

   assign wrap = (q == terminal);

   // clr wins over en so the controller can force q=0 on stop/completion
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         q <= '0;
      end else if (clr) begin
         q <= '0;
      end else if (en) begin
         q <= wrap ? '0 : q + BITS'(1);
      end
   end

endmodule

// File: rtl/mod_counter_scheduler.sv
// rtl/mod_counter_scheduler.sv - repeating modulo counter with run/pause/stop and shadowed period
module mod_counter_scheduler
   import mod_counter_pkg::*;
#(
   parameter int BITS = 8,
   parameter int REPW = 8
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            cfg_valid,
   input  logic [BITS-1:0] cfg_period,
   output logic            cfg_ready,
   input  logic            start,
   input  logic [REPW-1:0] start_reps,
   input  logic            pause,
   input  logic            stop,
   output logic            busy,
   output logic            tick,
   output logic            done,
   output logic [BITS-1:0] q
);

   state_t          state;
   state_t          state_next;
   logic [BITS-1:0] active_period;
   logic [BITS-1:0] shadow;
   logic            pending;
   logic [REPW-1:0] reps_left;

   logic            wrap;
   logic            running;
   logic            abort;
   logic            finish;
   logic            xfer;
   logic            cnt_en;
   logic            cnt_clr;

   assign running   = (state == ST_RUN) || (state == ST_PAUSE);
   assign abort     = running && stop;
   assign tick      = (state == ST_RUN) && wrap;
   // reps_left==0 means continuous, so only a loaded count can reach 1
   assign finish    = tick && !stop && (reps_left == REPW'(1));
   assign xfer      = cfg_valid && !pending;
   assign cfg_ready = !pending;
   assign busy      = running;
   assign done      = (state == ST_DONE);

   assign cnt_en  = (state == ST_RUN);
   assign cnt_clr = abort || finish || (state == ST_IDLE) || (state == ST_DONE);

   period_counter #(.BITS(BITS)) u_period_counter (
      .clk      (clk),
      .reset_n  (reset_n),
      .en       (cnt_en),
      .clr      (cnt_clr),
      .terminal (active_period),
      .q        (q),
      .wrap     (wrap)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE: begin
            if (start) state_next = ST_RUN;
         end
         ST_RUN: begin
            if (stop)        state_next = ST_IDLE;
            else if (finish) state_next = ST_DONE;
            else if (pause)  state_next = ST_PAUSE;
         end
         ST_PAUSE: begin
            if (stop)        state_next = ST_IDLE;
            else if (!pause) state_next = ST_RUN;
         end
         ST_DONE: begin
            state_next = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         reps_left <= '0;
      end else if ((state == ST_IDLE) && start) begin
         reps_left <= start_reps;
      end else if (tick && !stop && (reps_left != '0)) begin
         reps_left <= reps_left - REPW'(1);
      end
   end

   // A value landing on the final tick is left pending and folded in during DONE
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         active_period <= '0;
         shadow        <= '0;
         pending       <= 1'b0;
      end else if (abort) begin
         if (xfer)         active_period <= cfg_period;
         else if (pending) active_period <= shadow;
         pending <= 1'b0;
      end else if (!running) begin
         if (xfer) begin
            active_period <= cfg_period;
         end else if (pending) begin
            active_period <= shadow;
            pending       <= 1'b0;
         end
      end else if (tick && pending) begin
         active_period <= shadow;
         pending       <= 1'b0;
      end else if (xfer) begin
         shadow  <= cfg_period;
         pending <= 1'b1;
      end
   end

endmodule

// File: tb/tb_mod_counter_scheduler.sv
// tb/tb_mod_counter_scheduler.sv - directed scoreboard bench for mod_counter_scheduler
module tb_mod_counter_scheduler;

   logic       clk;
   logic       reset_n;
   logic       cfg_valid;
   logic [7:0] cfg_period;
   logic       cfg_ready;
   logic       start;
   logic [7:0] start_reps;
   logic       pause;
   logic       stop;
   logic       busy;
   logic       tick;
   logic       done;
   logic [7:0] q;

   typedef struct packed {
      logic       busy;
      logic       tick;
      logic       done;
      logic       rdy;
      logic [7:0] q;
   } obs_t;

   obs_t exp_q[$];
   int   n_pass;
   int   n_total;

   mod_counter_scheduler #(.BITS(8), .REPW(8)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .cfg_valid  (cfg_valid),
      .cfg_period (cfg_period),
      .cfg_ready  (cfg_ready),
      .start      (start),
      .start_reps (start_reps),
      .pause      (pause),
      .stop       (stop),
      .busy       (busy),
      .tick       (tick),
      .done       (done),
      .q          (q)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic compare(input string tag);
      obs_t e;
      obs_t o;
      e = exp_q.pop_front();
      o = '{busy: busy, tick: tick, done: done, rdy: cfg_ready, q: q};
      n_total++;
      assert (o === e) n_pass++;
      else $error("FAIL %s observed busy/tick/done/rdy/q=%b%b%b%b/%0d expected=%b%b%b%b/%0d",
                  tag, o.busy, o.tick, o.done, o.rdy, o.q, e.busy, e.tick, e.done, e.rdy, e.q);
   endtask

   task automatic chk_now(input string tag, input logic b, input logic t, input logic d,
                          input logic r, input logic [7:0] qv);
      exp_q.push_back('{busy: b, tick: t, done: d, rdy: r, q: qv});
      compare(tag);
   endtask

   // one clock step: inputs already applied, outputs checked mid-cycle
   task automatic chk(input string tag, input logic b, input logic t, input logic d,
                      input logic r, input logic [7:0] qv);
      exp_q.push_back('{busy: b, tick: t, done: d, rdy: r, q: qv});
      @(negedge clk);
      compare(tag);
      @(posedge clk);
      #1;
      start     = 1'b0;
      cfg_valid = 1'b0;
   endtask

   initial begin
      n_pass     = 0;
      n_total    = 0;
      reset_n    = 1'b0;
      cfg_valid  = 1'b0;
      cfg_period = '0;
      start      = 1'b0;
      start_reps = '0;
      pause      = 1'b0;
      stop       = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk_now("reset", 0, 0, 0, 1, 0);
      reset_n = 1'b1;

      // period 3, two reps
      cfg_valid = 1'b1; cfg_period = 8'd3;
      chk("a_cfg", 0, 0, 0, 1, 0);
      start = 1'b1; start_reps = 8'd2;
      chk("a_start", 0, 0, 0, 1, 0);
      for (int r = 0; r < 2; r++)
         for (int i = 0; i < 4; i++)
            chk("a_run", 1, (i == 3), 0, 1, 8'(i));
      chk("a_done", 0, 0, 1, 1, 0);
      chk("a_idle", 0, 0, 0, 1, 0);

      // period 0, four reps
      cfg_valid = 1'b1; cfg_period = 8'd0;
      chk("b_cfg", 0, 0, 0, 1, 0);
      start = 1'b1; start_reps = 8'd4;
      chk("b_start", 0, 0, 0, 1, 0);
      repeat (4) chk("b_tick", 1, 1, 0, 1, 0);
      chk("b_done", 0, 0, 1, 1, 0);
      chk("b_idle", 0, 0, 0, 1, 0);

      // continuous period 5, reconfigure to 2 at q=1
      cfg_valid = 1'b1; cfg_period = 8'd5;
      chk("c_cfg", 0, 0, 0, 1, 0);
      start = 1'b1; start_reps = 8'd0;
      chk("c_start", 0, 0, 0, 1, 0);
      chk("c_q0", 1, 0, 0, 1, 0);
      cfg_valid = 1'b1; cfg_period = 8'd2;
      chk("c_q1", 1, 0, 0, 1, 1);
      for (int i = 2; i < 5; i++) chk("c_pend", 1, 0, 0, 0, 8'(i));
      chk("c_wrap5", 1, 1, 0, 0, 5);
      for (int r = 0; r < 2; r++)
         for (int i = 0; i < 3; i++)
            chk("c_run2", 1, (i == 2), 0, 1, 8'(i));
      stop = 1'b1;
      chk("c_stop", 1, 0, 0, 1, 0);
      stop = 1'b0;
      chk("c_idle", 0, 0, 0, 1, 0);

      // period 4, two reps, pause three cycles from q=2
      cfg_valid = 1'b1; cfg_period = 8'd4;
      chk("d_cfg", 0, 0, 0, 1, 0);
      start = 1'b1; start_reps = 8'd2;
      chk("d_start", 0, 0, 0, 1, 0);
      chk("d_q0", 1, 0, 0, 1, 0);
      chk("d_q1", 1, 0, 0, 1, 1);
      pause = 1'b1;
      chk("d_q2", 1, 0, 0, 1, 2);
      chk("d_p1", 1, 0, 0, 1, 3);
      chk("d_p2", 1, 0, 0, 1, 3);
      pause = 1'b0;
      chk("d_p3", 1, 0, 0, 1, 3);
      chk("d_q3", 1, 0, 0, 1, 3);
      chk("d_tick", 1, 1, 0, 1, 4);
      for (int i = 0; i < 5; i++) chk("d_run", 1, (i == 4), 0, 1, 8'(i));
      chk("d_done", 0, 0, 1, 1, 0);
      chk("d_idle", 0, 0, 0, 1, 0);

      // stop with pause and tick, pending value 1 committed by stop
      cfg_valid = 1'b1; cfg_period = 8'd2;
      chk("e_cfg", 0, 0, 0, 1, 0);
      start = 1'b1; start_reps = 8'd0;
      chk("e_start", 0, 0, 0, 1, 0);
      cfg_valid = 1'b1; cfg_period = 8'd1;
      chk("e_q0", 1, 0, 0, 1, 0);
      chk("e_q1", 1, 0, 0, 0, 1);
      stop = 1'b1; pause = 1'b1;
      chk("e_tick", 1, 1, 0, 0, 2);
      stop = 1'b0; pause = 1'b0;
      chk("e_idle", 0, 0, 0, 1, 0);
      start = 1'b1; start_reps = 8'd1;
      chk("e_start2", 0, 0, 0, 1, 0);
      chk("e_q0b", 1, 0, 0, 1, 0);
      chk("e_tickb", 1, 1, 0, 1, 1);
      chk("e_done", 0, 0, 1, 1, 0);
      chk("e_idle2", 0, 0, 0, 1, 0);

      // reset mid-run with a pending value
      cfg_valid = 1'b1; cfg_period = 8'd3;
      chk("f_cfg", 0, 0, 0, 1, 0);
      start = 1'b1; start_reps = 8'd0;
      chk("f_start", 0, 0, 0, 1, 0);
      cfg_valid = 1'b1; cfg_period = 8'd2;
      chk("f_q0", 1, 0, 0, 1, 0);
      chk("f_q1", 1, 0, 0, 0, 1);
      reset_n = 1'b0;
      #1;
      chk_now("f_rst", 0, 0, 0, 1, 0);
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      start = 1'b1; start_reps = 8'd1;
      chk("f_start2", 0, 0, 0, 1, 0);
      chk("f_tick0", 1, 1, 0, 1, 0);
      chk("f_done", 0, 0, 1, 1, 0);
      chk("f_idle", 0, 0, 0, 1, 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
